// File: rtl/unary_gate_detect_pkg.sv
// Shared types and helpers for the gate detector family: FSM encoding,
// GPIO direction codes and the response-to-class mapping.
package gate_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_NOT  = 2'd1,
    CLS_BUF  = 2'd2
  } cls_t;

  // resp[0] is the output seen with input 0, resp[1] with input 1.
  function automatic cls_t classify(input logic [1:0] resp);
    case (resp)
      2'b01:   return CLS_NOT;
      2'b10:   return CLS_BUF;
      default: return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/unary_gate_detect_settle_timer.sv
// Loadable down-counter that pulses expire during the last enabled cycle
// of a SETTLE_CYCLES-long wait.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  localparam int W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count;

  // Load the full wait, then count down one step per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(SETTLE_CYCLES);
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = en && (count == W'(1));

endmodule

// File: rtl/unary_gate_detect.sv
// Unary gate detector: drives pin 2k of each pair with 0 then 1, samples
// pin 2k+1 after a settle wait and classifies the pair as NOT/BUFFER/none.
module unary_gate_detect
  import gate_detect_pkg::*;
#(
  parameter int NPINS         = 12,
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_MATCH     = 3,
  localparam int PAIRS = NPINS / 2,
  localparam int CW    = $clog2(PAIRS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NPINS-1:0] pins_in,
  output logic [NPINS-1:0] pins_out,
  output logic [NPINS-1:0] pins_dir,
  output logic             busy,
  output logic             done,
  output logic [PAIRS-1:0] not_mask,
  output logic [PAIRS-1:0] buf_mask,
  output logic [CW-1:0]    not_cnt,
  output logic [CW-1:0]    buf_cnt,
  output logic             is_not,
  output logic             is_buf
);

  localparam int PW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [31:0] MIN_U = 32'(MIN_MATCH);

  state_t state_reg, state_next;
  logic [PW-1:0] pair_reg, pair_next;
  logic tv_reg, tv_next;
  logic resp0_reg, resp0_next;

  logic [NPINS-1:0] pins_out_next, pins_dir_next;
  logic busy_next, done_next;
  logic [PAIRS-1:0] not_mask_next, buf_mask_next;
  logic [CW-1:0] not_cnt_next, buf_cnt_next;
  logic is_not_next, is_buf_next;

  logic timer_load, timer_en, timer_expire;
  logic [PAIRS-1:0] pair_hot, hot_next, odd_in, even_in;
  logic resp_bit, drive_en, unused_even;
  cls_t cls;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  assign pair_hot = PAIRS'(1) << pair_reg;
  assign hot_next = PAIRS'(1) << pair_next;
  assign resp_bit = |(odd_in & pair_hot);
  assign drive_en = (state_next == ST_DRIVE) || (state_next == ST_SETTLE) ||
                    (state_next == ST_SAMPLE);
  assign unused_even = ^even_in;

  // Per-pair pin split and drive pattern for the upcoming state.
  for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
    assign odd_in[gi]             = pins_in[2*gi+1];
    assign even_in[gi]            = pins_in[2*gi];
    assign pins_dir_next[2*gi]    = (drive_en && hot_next[gi]) ? DIR_OUT : DIR_IN;
    assign pins_dir_next[2*gi+1]  = DIR_IN;
    assign pins_out_next[2*gi]    = drive_en && hot_next[gi] && tv_next;
    assign pins_out_next[2*gi+1]  = 1'b0;
  end

  // Next-state, result and status logic; abort overrides any busy state.
  always_comb begin
    state_next    = state_reg;
    pair_next     = pair_reg;
    tv_next       = tv_reg;
    resp0_next    = resp0_reg;
    busy_next     = busy;
    done_next     = done;
    not_mask_next = not_mask;
    buf_mask_next = buf_mask;
    not_cnt_next  = not_cnt;
    buf_cnt_next  = buf_cnt;
    is_not_next   = is_not;
    is_buf_next   = is_buf;
    timer_load    = 1'b0;
    timer_en      = 1'b0;
    cls           = CLS_NONE;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          not_mask_next = '0;
          buf_mask_next = '0;
          not_cnt_next  = '0;
          buf_cnt_next  = '0;
          is_not_next   = 1'b0;
          is_buf_next   = 1'b0;
          done_next     = 1'b0;
          busy_next     = 1'b1;
          pair_next     = '0;
          tv_next       = 1'b0;
          state_next    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        timer_load = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        timer_en = 1'b1;
        if (timer_expire) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (!tv_reg) begin
          resp0_next = resp_bit;
          tv_next    = 1'b1;
          state_next = ST_DRIVE;
        end else begin
          cls = classify({resp_bit, resp0_reg});
          if (cls == CLS_NOT) begin
            not_mask_next = not_mask | pair_hot;
            not_cnt_next  = not_cnt + CW'(1);
          end else if (cls == CLS_BUF) begin
            buf_mask_next = buf_mask | pair_hot;
            buf_cnt_next  = buf_cnt + CW'(1);
          end
          if (pair_reg == PW'(PAIRS - 1)) begin
            busy_next   = 1'b0;
            done_next   = 1'b1;
            is_not_next = 32'(not_cnt_next) >= MIN_U;
            is_buf_next = 32'(buf_cnt_next) >= MIN_U;
            state_next  = ST_DONE;
          end else begin
            pair_next  = pair_reg + PW'(1);
            tv_next    = 1'b0;
            state_next = ST_DRIVE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (abort && (state_reg == ST_DRIVE || state_reg == ST_SETTLE ||
                  state_reg == ST_SAMPLE)) begin
      state_next    = ST_IDLE;
      pair_next     = '0;
      tv_next       = 1'b0;
      resp0_next    = 1'b0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
      not_mask_next = '0;
      buf_mask_next = '0;
      not_cnt_next  = '0;
      buf_cnt_next  = '0;
      is_not_next   = 1'b0;
      is_buf_next   = 1'b0;
    end
  end

  // State and registered outputs; reset releases the GPIO bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pair_reg  <= '0;
      tv_reg    <= 1'b0;
      resp0_reg <= 1'b0;
      pins_out  <= '0;
      pins_dir  <= {NPINS{DIR_IN}};
      busy      <= 1'b0;
      done      <= 1'b0;
      not_mask  <= '0;
      buf_mask  <= '0;
      not_cnt   <= '0;
      buf_cnt   <= '0;
      is_not    <= 1'b0;
      is_buf    <= 1'b0;
    end else begin
      state_reg <= state_next;
      pair_reg  <= pair_next;
      tv_reg    <= tv_next;
      resp0_reg <= resp0_next;
      pins_out  <= pins_out_next;
      pins_dir  <= pins_dir_next;
      busy      <= busy_next;
      done      <= done_next;
      not_mask  <= not_mask_next;
      buf_mask  <= buf_mask_next;
      not_cnt   <= not_cnt_next;
      buf_cnt   <= buf_cnt_next;
      is_not    <= is_not_next;
      is_buf    <= is_buf_next;
    end
  end

endmodule

// File: tb/tb_unary_gate_detect.sv
// Directed bench: per-pair gate models on the GPIO bus, expected results
// queued at each start and compared when done rises.
module tb_unary_gate_detect;

  localparam int NPINS = 12;
  localparam int SETTLE = 4;
  localparam int MINM = 3;
  localparam int PAIRS = NPINS / 2;
  localparam int CW = $clog2(PAIRS + 1);
  localparam int LAT = PAIRS * 2 * (SETTLE + 2);
  localparam logic [NPINS-1:0] ODD = 12'hAAA;

  // pair behaviour codes
  localparam logic [1:0] M_NOT = 2'd0, M_BUF = 2'd1, M_ST1 = 2'd2, M_ST0 = 2'd3;

  typedef struct packed {
    logic [PAIRS-1:0] nm;
    logic [PAIRS-1:0] bm;
    logic [CW-1:0]    nc;
    logic [CW-1:0]    bc;
    logic             in_;
    logic             ib;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [NPINS-1:0] pins_in, pins_out, pins_dir;
  logic busy, done, is_not, is_buf;
  logic [PAIRS-1:0] not_mask, buf_mask;
  logic [CW-1:0] not_cnt, buf_cnt;

  logic [1:0] mode [PAIRS];
  res_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  unary_gate_detect #(.NPINS(NPINS), .SETTLE_CYCLES(SETTLE), .MIN_MATCH(MINM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pins_in(pins_in), .pins_out(pins_out), .pins_dir(pins_dir),
    .busy(busy), .done(done), .not_mask(not_mask), .buf_mask(buf_mask),
    .not_cnt(not_cnt), .buf_cnt(buf_cnt), .is_not(is_not), .is_buf(is_buf)
  );

  // Gate under test on each pair: output pin reacts to driven input pin.
  for (genvar gi = 0; gi < PAIRS; gi++) begin : g_model
    assign pins_in[2*gi] = 1'b0;
    assign pins_in[2*gi+1] = (mode[gi] == M_NOT) ? ~pins_out[2*gi] :
                             (mode[gi] == M_BUF) ?  pins_out[2*gi] :
                             (mode[gi] == M_ST1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model();
    res_t r;
    int nc, bc;
    r = '0;
    nc = 0;
    bc = 0;
    for (int k = 0; k < PAIRS; k++) begin
      if (mode[k] == M_NOT) begin
        r.nm = r.nm | (PAIRS'(1) << k);
        nc++;
      end else if (mode[k] == M_BUF) begin
        r.bm = r.bm | (PAIRS'(1) << k);
        bc++;
      end
    end
    r.nc = CW'(nc);
    r.bc = CW'(bc);
    r.in_ = (nc >= MINM);
    r.ib = (bc >= MINM);
    return r;
  endfunction

  task automatic set_modes(input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                           input logic [1:0] m3, input logic [1:0] m4, input logic [1:0] m5);
    mode[0] = m0; mode[1] = m1; mode[2] = m2;
    mode[3] = m3; mode[4] = m4; mode[5] = m5;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dir"}, 32'(pins_dir), 32'd0);
    chk({tag, "_out"}, 32'(pins_out), 32'd0);
    chk({tag, "_masks"}, 32'({not_mask, buf_mask}), 32'd0);
    chk({tag, "_cnts"}, 32'({not_cnt, buf_cnt, is_not, is_buf}), 32'd0);
  endtask

  // One scan with optional stray start, abort or reset at a given cycle.
  task automatic run_scan(input string name, input int pulse_at, input int abort_at, input int rst_at);
    res_t exp;
    bit fin;
    bit legal;
    sb.push_back(model());
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    chk({name, "_done_clr"}, 32'(done), 32'd0);
    fin = 1'b0;
    for (int n = 1; n <= LAT + 20 && !fin; n++) begin
      @(posedge clk);
      #1;
      start = (n == pulse_at);
      legal = (pins_dir == '0) || ($onehot(pins_dir) && ((pins_dir & ODD) == '0));
      chk({name, "_dir_legal"}, 32'(legal), 32'd1);
      chk({name, "_out_undriven"}, 32'(pins_out & ~pins_dir), 32'd0);
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk_cleared({name, "_rst"});
        exp = sb.pop_front();
        fin = 1'b1;
      end else if (n == abort_at) begin
        abort = 1'b1;
      end else if (abort_at != 0 && n == abort_at + 1) begin
        abort = 1'b0;
        chk_cleared({name, "_abort"});
        exp = sb.pop_front();
        fin = 1'b1;
      end else if (done === 1'b1) begin
        fin = 1'b1;
        exp = sb.pop_front();
        chk({name, "_done_edge"}, 32'(n), 32'(LAT));
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_dir_end"}, 32'(pins_dir), 32'd0);
        chk({name, "_not_mask"}, 32'(not_mask), 32'(exp.nm));
        chk({name, "_buf_mask"}, 32'(buf_mask), 32'(exp.bm));
        chk({name, "_not_cnt"}, 32'(not_cnt), 32'(exp.nc));
        chk({name, "_buf_cnt"}, 32'(buf_cnt), 32'(exp.bc));
        chk({name, "_is_not"}, 32'(is_not), 32'(exp.in_));
        chk({name, "_is_buf"}, 32'(is_buf), 32'(exp.ib));
      end
    end
    start = 1'b0;
    if (!fin) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      exp = sb.pop_front();
    end
    if (rst) begin
      @(negedge clk);
      rst = 1'b0;
    end
    $display("scan %s: not_mask=%b buf_mask=%b not_cnt=%0d buf_cnt=%0d is_not=%0d is_buf=%0d done=%0d",
             name, not_mask, buf_mask, not_cnt, buf_cnt, is_not, is_buf, done);
  endtask

  initial begin
    set_modes(M_NOT, M_NOT, M_NOT, M_NOT, M_NOT, M_NOT);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cleared("idle");

    // all NOT, with a stray start at cycle 10 that must be ignored
    run_scan("all_not", 10, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", 32'(done), 32'd1);
    chk("done_dir_idle", 32'(pins_dir), 32'd0);

    set_modes(M_BUF, M_BUF, M_BUF, M_BUF, M_BUF, M_BUF);
    run_scan("all_buf", 0, 0, 0);

    set_modes(M_NOT, M_ST1, M_NOT, M_ST1, M_NOT, M_ST1);
    run_scan("not_even", 0, 0, 0);

    set_modes(M_NOT, M_ST1, M_NOT, M_ST1, M_ST1, M_ST1);
    run_scan("not_two", 0, 0, 0);

    // abort mid-scan, then a clean rerun
    set_modes(M_NOT, M_NOT, M_NOT, M_NOT, M_NOT, M_NOT);
    run_scan("abort30", 0, 30, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("abort_idle");
    run_scan("after_abort", 0, 0, 0);

    // asynchronous reset mid-scan, then a mixed rerun
    run_scan("rst40", 0, 0, 40);
    set_modes(M_BUF, M_NOT, M_ST0, M_BUF, M_NOT, M_BUF);
    run_scan("mixed", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
